// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer around a streaming sobel_core: feeds one frame of pixels, pads
// the core pipeline, drops the window-centre lag and frames the edge results.
module sobel_frame_ctrl #(
  parameter int unsigned WIDTH  = 512,
  parameter int unsigned HEIGHT = 512,
  parameter int unsigned SKIP   = WIDTH + 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] src_pixel,
  input  logic       src_valid,
  output logic       src_ready,
  output logic [7:0] core_pixel,
  output logic       core_valid,
  input  logic [7:0] core_pixel_out,
  input  logic       core_valid_out,
  output logic [7:0] out_pixel,
  output logic       out_valid,
  output logic       out_last,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned PW = (SKIP > 1) ? $clog2(SKIP) : 1;
  localparam int unsigned SW = $clog2(SKIP + 1);

  typedef enum logic [2:0] {IDLE, FEED, PAD, DRAIN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] in_col;
  logic [RW-1:0] in_row;
  logic [CW-1:0] out_col;
  logic [RW-1:0] out_row;
  logic [PW-1:0] pad_cnt;
  logic [SW-1:0] skip_cnt;
  logic          fin;

  logic accept_c;
  logic in_end_c;
  logic out_end_c;
  logic pad_end_c;
  logic take_c;
  logic emit_c;
  logic border_c;

  assign src_ready = (state == FEED);
  assign busy      = (state == FEED) || (state == PAD) || (state == DRAIN);
  assign done      = (state == DONE);

  assign accept_c  = src_valid && src_ready && !abort;
  assign in_end_c  = (in_col == CW'(WIDTH - 1)) && (in_row == RW'(HEIGHT - 1));
  assign out_end_c = (out_col == CW'(WIDTH - 1)) && (out_row == RW'(HEIGHT - 1));
  assign pad_end_c = (pad_cnt == PW'(SKIP - 1));
  // Core results are only consumed while a frame is live and not yet complete.
  assign take_c    = core_valid_out && (state != IDLE) && !fin && !abort;
  assign emit_c    = take_c && (skip_cnt == SW'(SKIP));
  assign border_c  = (out_row == '0) || (out_row == RW'(HEIGHT - 1)) ||
                     (out_col == '0) || (out_col == CW'(WIDTH - 1));

  // Core drive: accepted source beats pass straight through, PAD pushes zeros.
  always_comb begin
    core_valid = 1'b0;
    core_pixel = '0;
    if (accept_c) begin
      core_valid = 1'b1;
      core_pixel = src_pixel;
    end else if ((state == PAD) && !abort) begin
      core_valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_col    <= '0;
      in_row    <= '0;
      out_col   <= '0;
      out_row   <= '0;
      pad_cnt   <= '0;
      skip_cnt  <= '0;
      fin       <= 1'b0;
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_last  <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      in_col    <= '0;
      in_row    <= '0;
      out_col   <= '0;
      out_row   <= '0;
      pad_cnt   <= '0;
      skip_cnt  <= '0;
      fin       <= 1'b0;
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= emit_c;
      out_last  <= emit_c && out_end_c;
      out_pixel <= (emit_c && !border_c) ? core_pixel_out : '0;

      if (take_c && !emit_c) skip_cnt <= skip_cnt + 1'b1;

      if (emit_c) begin
        if (out_col == CW'(WIDTH - 1)) begin
          out_col <= '0;
          out_row <= (out_row == RW'(HEIGHT - 1)) ? '0 : out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
        if (out_end_c) fin <= 1'b1;
      end

      if (accept_c) begin
        if (in_col == CW'(WIDTH - 1)) begin
          in_col <= '0;
          in_row <= (in_row == RW'(HEIGHT - 1)) ? '0 : in_row + 1'b1;
        end else begin
          in_col <= in_col + 1'b1;
        end
      end

      case (state)
        IDLE:  if (start) state <= FEED;
        FEED:  if (accept_c && in_end_c) state <= PAD;
        PAD: begin
          if (pad_end_c) begin
            pad_cnt <= '0;
            state   <= fin ? DONE : DRAIN;
          end else begin
            pad_cnt <= pad_cnt + 1'b1;
          end
        end
        DRAIN: if (fin) state <= DONE;
        DONE: begin
          state    <= IDLE;
          in_col   <= '0;
          in_row   <= '0;
          out_col  <= '0;
          out_row  <= '0;
          skip_cnt <= '0;
          fin      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Bench for sobel_frame_ctrl: a beat-lag echo core, randomized/directed frames,
// and a queue model of the expected edge-result stream.
module tb_sobel_frame_ctrl;

  localparam int unsigned W    = 4;
  localparam int unsigned H    = 4;
  localparam int unsigned SKIP = 5;
  localparam int unsigned NPIX = W * H;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] src_pixel = 8'h0;
  logic       src_valid = 1'b0;
  logic       src_ready;
  logic [7:0] core_pixel;
  logic       core_valid;
  logic [7:0] core_pixel_out;
  logic       core_valid_out;
  logic [7:0] out_pixel;
  logic       out_valid;
  logic       out_last;
  logic       busy;
  logic       done;

  sobel_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .SKIP(SKIP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .src_pixel(src_pixel), .src_valid(src_valid), .src_ready(src_ready),
    .core_pixel(core_pixel), .core_valid(core_valid),
    .core_pixel_out(core_pixel_out), .core_valid_out(core_valid_out),
    .out_pixel(out_pixel), .out_valid(out_valid), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Echo core: every input beat yields an output beat carrying the pixel from SKIP beats earlier.
  logic [7:0] hist [SKIP];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_valid_out <= 1'b0;
      core_pixel_out <= 8'h0;
      for (int i = 0; i < SKIP; i++) hist[i] <= 8'h0;
    end else begin
      core_valid_out <= core_valid;
      core_pixel_out <= core_valid ? hist[SKIP-1] : 8'h0;
      if (core_valid) begin
        hist[0] <= core_pixel;
        for (int i = 1; i < SKIP; i++) hist[i] <= hist[i-1];
      end
    end
  end

  typedef struct { logic [7:0] pix; logic last; } exp_t;

  int         total = 0;
  int         bad = 0;
  exp_t       exp_q[$];
  exp_t       cmp_e;
  logic [7:0] obs_pix[$];
  int         obs_last_idx = -1;
  int         done_cnt = 0;
  int         last_cnt = 0;
  int         cyc = 0;
  int         last_cyc = -100;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Output stream checker against the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        obs_pix.push_back(out_pixel);
        if (out_last) begin
          obs_last_idx = obs_pix.size() - 1;
          last_cnt++;
          last_cyc = cyc;
        end
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          cmp_e = exp_q.pop_front();
          check("out_pixel", int'(out_pixel), int'(cmp_e.pix));
          check("out_last", int'(out_last), int'(cmp_e.last));
        end
      end else begin
        check("out_last_idle", int'(out_last), 0);
      end
      if (done) begin
        done_cnt++;
        check("done_after_last", cyc - last_cyc, 1);
        check("busy_in_done", int'(busy), 0);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_src_ready"}, int'(src_ready), 0);
    check({tag, "_core_valid"}, int'(core_valid), 0);
    check({tag, "_core_pixel"}, int'(core_pixel), 0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_pixel"}, int'(out_pixel), 0);
    check({tag, "_out_last"}, int'(out_last), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  // mode 0: continuous ramp 16*k, 1: alternating valid ramp, 2: random valid and pixels.
  task automatic run_frame(input int mode, input bit poke, input int abort_at, input bit rst_pad);
    int         acc;
    int         n;
    int         done_at;
    int         r;
    int         c;
    logic       v;
    logic [7:0] p;
    exp_t       e;
    obs_pix.delete();
    obs_last_idx = -1;
    start = 1'b1;
    src_valid = 1'b0;
    @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_src_ready", int'(src_ready), 0);
    check("idle_done", int'(done), 0);
    @(posedge clk); #1;
    start = 1'b0;
    acc = 0;
    n = 0;
    while (acc < NPIX && n < 400) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (n % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      p = (mode < 2) ? 8'(16 * acc) : 8'($urandom);
      if (abort_at > 0 && acc == abort_at) begin
        abort = 1'b1;
        src_valid = 1'b1;
        src_pixel = p;
        @(negedge clk);
        check("abort_core_valid", int'(core_valid), 0);
        @(posedge clk); #1;
        abort = 1'b0;
        src_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_src_ready", int'(src_ready), 0);
        check("abort_done", int'(done), 0);
        @(posedge clk); #1;
        return;
      end
      src_valid = v;
      src_pixel = p;
      start = poke && (n == 3);
      @(negedge clk);
      check("feed_src_ready", int'(src_ready), 1);
      check("feed_core_valid", int'(core_valid), int'(v));
      check("feed_core_pixel", int'(core_pixel), v ? int'(p) : 0);
      check("feed_busy", int'(busy), 1);
      if (v) begin
        r = acc / W;
        c = acc % W;
        e.pix  = (r == 0 || r == H - 1 || c == 0 || c == W - 1) ? 8'h0 : p;
        e.last = (acc == NPIX - 1);
        exp_q.push_back(e);
        acc++;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    src_valid = 1'b0;
    if (acc < NPIX) check("feed_timeout", acc, NPIX);

    for (int i = 0; i < SKIP; i++) begin
      src_valid = 1'($urandom_range(0, 1));
      src_pixel = 8'($urandom);
      @(negedge clk);
      check("pad_src_ready", int'(src_ready), 0);
      check("pad_core_valid", int'(core_valid), 1);
      check("pad_core_pixel", int'(core_pixel), 0);
      check("pad_busy", int'(busy), 1);
      if (rst_pad && i == 2) begin
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_pad");
        @(posedge clk); #1;
        rst_n = 1'b1;
        src_valid = 1'b0;
        exp_q.delete();
        return;
      end
      @(posedge clk); #1;
    end
    src_valid = 1'b0;

    done_at = -1;
    for (int i = 0; i < 64 && done_at < 0; i++) begin
      start = poke && (i == 0);
      @(negedge clk);
      if (done) done_at = i;
      else check("drain_busy", int'(busy), 1);
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("done_latency", done_at, 2);
    check("frame_out_count", obs_pix.size(), NPIX);
    check("frame_last_index", obs_last_idx, NPIX - 1);
    check("exp_q_empty", exp_q.size(), 0);
  endtask

  // Hand-derived values for a ramp frame: interior pixels 5,6,9,10 of 16*k.
  task automatic check_ramp_literals();
    int border_sum;
    check("lit_count", obs_pix.size(), 16);
    if (obs_pix.size() == 16) begin
      check("lit_p5", int'(obs_pix[5]), 80);
      check("lit_p6", int'(obs_pix[6]), 96);
      check("lit_p9", int'(obs_pix[9]), 144);
      check("lit_p10", int'(obs_pix[10]), 160);
      border_sum = 0;
      for (int k = 0; k < 16; k++)
        if (k != 5 && k != 6 && k != 9 && k != 10) border_sum += int'(obs_pix[k]);
      check("lit_border_zero", border_sum, 0);
    end
  endtask

  initial begin
    int last_before;
    #1 rst_n = 1'b0;
    #2 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_frame(0, 1'b0, 0, 1'b0);
    check_ramp_literals();
    check("done_cnt_f1", done_cnt, 1);

    run_frame(1, 1'b1, 0, 1'b0);
    check_ramp_literals();
    check("done_cnt_f2", done_cnt, 2);

    run_frame(0, 1'b0, 7, 1'b0);
    check("done_cnt_abort", done_cnt, 2);

    run_frame(2, 1'b0, 0, 1'b0);
    check("done_cnt_f3", done_cnt, 3);

    run_frame(2, 1'b0, 0, 1'b1);
    check("done_cnt_rst", done_cnt, 3);

    run_frame(0, 1'b0, 0, 1'b0);
    check_ramp_literals();
    check("done_cnt_f4", done_cnt, 4);

    last_before = last_cnt;
    run_frame(2, 1'b0, 0, 1'b0);
    run_frame(2, 1'b0, 0, 1'b0);
    check("done_cnt_b2b", done_cnt, 6);
    check("last_cnt_b2b", last_cnt - last_before, 2);

    for (int f = 0; f < 4; f++) run_frame(2, 1'($urandom_range(0, 1)), 0, 1'b0);
    check("done_cnt_final", done_cnt, 10);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
